ucsbece154a_dmem_responder: RTL

Memory-side responder for the processor's data bus. It accepts load and store requests over a valid/ready handshake, inserts a programmable number of wait states, and returns one response per request. It owns a word-addressed `DATA` array mapped at `BASE_ADDR`, and sits between `riscv` and the data port in `ucsbece154a_top`. This gives the core a latency-bearing memory in place of the zero-wait combinational model.

---
 rtl/ucsbece154a_dmem_pkg.sv | 17 +
 rtl/ucsbece154a_dmem_array.sv | 31 +++
 rtl/ucsbece154a_dmem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ucsbece154a_dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ucsbece154a_dmem_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1000_0000;
  localparam int          WORD_W         = 32;
  localparam int          BE_W           = 4;
  localparam int          CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ucsbece154a_dmem_array.sv
// Word array DATA with byte-enabled synchronous write and registered read.
// Latency: write and read both take effect on the clock edge they are enabled.
// Backpressure: none; ports: clk, wr_en/wr_be/wdata, rd_en/rdata, shared index.
module ucsbece154a_dmem_array
  import ucsbece154a_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [AW-1:0]     index,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rdata
);

  // Deliberately not reset: contents survive a responder reset.
  logic [WORD_W-1:0] DATA [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) DATA[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) rdata <= DATA[index];
  end

endmodule

// File: rtl/ucsbece154a_dmem_responder.sv
// Data-bus memory responder: one load/store at a time with WAIT_CYCLES wait states.
// Latency: response valid WAIT_CYCLES+1 cycles after the acceptance cycle.
// Backpressure: holds RESP (data/err stable) until rsp_ready; req_ready low while busy.
// Ports: clk, reset (async active-low), req_valid/req_ready/req_we/req_addr/req_wdata/req_be,
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err.
// Optional macro UCSBECE154A_DMEM_ERR_EN: flags out-of-range or misaligned accesses.
module ucsbece154a_dmem_responder
  import ucsbece154a_dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_ok_q;
  logic              err_q;
  logic              accept, commit;

  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic [31:0]       offset;
  logic [AW-1:0]     index;
  logic              cur_err;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_bits;

  // With zero wait states the commit happens on the acceptance edge, so the
  // request has to come straight from the inputs rather than the capture regs.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;

  // 32-bit wrapping subtraction: addresses below BASE_ADDR become huge offsets.
  assign offset      = cur_addr - BASE_ADDR;
  assign index       = offset[AW+1:2];
  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

`ifdef UCSBECE154A_DMEM_ERR_EN
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  assign cur_err = (offset >= SPAN) || (cur_addr[1:0] != 2'b00);
`else
  assign cur_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so a zero-wait request cannot write during reset.
        if (req_valid && reset) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (commit) begin
        rd_ok_q <= !cur_we && !cur_err;
        err_q   <= cur_err;
      end
    end
  end

  ucsbece154a_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .wr_en (commit && cur_we && !cur_err),
    .wr_be (cur_be),
    .index (index),
    .wdata (cur_wdata),
    .rd_en (commit && !cur_we && !cur_err),
    .rdata (arr_rdata)
  );

  assign req_ready = reset && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  // The array read register is not reset; rd_ok_q forces 0 for stores, errors and reset.
  assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
  assign rsp_err   = err_q;

endmodule
